// File: rtl/input_unit_pkg.sv
// Shared router constants and flit type used by the input unit and its FIFO.
package input_unit_pkg;

  localparam int unsigned ROUTER_M      = 5;
  localparam int unsigned ROUTER_DEST_W = 3;
  localparam int unsigned FLIT_W        = 32;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO: storage, wrapping pointers and occupancy count with clock enable.
module fifo_sync #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ce,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = ce && wr_en && !full;
  assign rd_fire = ce && rd_en && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_fire && !rd_fire)      count <= count + CNT_W'(1);
      else if (rd_fire && !wr_fire) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/input_unit.sv
// Router input port: buffers flits with their decoded one-hot request and drops unroutable ones.
module input_unit
  import input_unit_pkg::*;
#(
  parameter int unsigned M      = ROUTER_M,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = FLIT_W,
  parameter int unsigned DEST_W = ROUTER_DEST_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ce,
  input  logic                       i_valid,
  input  logic [DATA_W-1:0]          i_data,
  output logic                       o_en,
  output logic [0:M-1]               o_output_req,
  output logic [DATA_W-1:0]          o_data,
  input  logic                       i_grant,
  output logic                       o_drop,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  logic [DEST_W-1:0]     dest;
  logic                  dest_ok;
  logic                  accept;
  logic                  drop_d;
  logic                  full;
  logic                  empty;
  logic [0:M-1]          req_dec;
  logic [0:M-1]          head_req;
  logic [M+DATA_W-1:0]   wr_word;
  logic [M+DATA_W-1:0]   rd_word;

  assign dest    = i_data[DEST_W-1:0];
  assign dest_ok = (32'(dest) < M);
  assign accept  = ce && i_valid && o_en;
  assign drop_d  = accept && !dest_ok;

  always_comb begin
    req_dec = '0;
    for (int unsigned j = 0; j < M; j++) begin
      req_dec[j] = (32'(dest) == j);
    end
  end

  assign wr_word = {req_dec, i_data};

  fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (M + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .wr_en   (accept && dest_ok),
    .wr_data (wr_word),
    .rd_en   (i_grant),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty),
    .count   (o_count)
  );

  assign o_en         = !full;
  assign head_req     = rd_word[DATA_W +: M];
  assign o_output_req = empty ? '0 : head_req;
  assign o_data       = rd_word[DATA_W-1:0];

  // drop_d already includes ce, so the pulse self-clears even while ce is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) o_drop <= 1'b0;
    else          o_drop <= drop_d;
  end

endmodule

// File: tb/tb_input_unit.sv
// Directed and randomized check of input_unit against a queue-based reference model.
module tb_input_unit;
  import input_unit_pkg::*;

  localparam int unsigned M      = 5;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEST_W = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce;
  logic          i_valid;
  flit_t         i_data;
  logic          o_en;
  logic [0:M-1]  o_output_req;
  flit_t         o_data;
  logic          i_grant;
  logic          o_drop;
  logic [2:0]    o_count;

  int            passes = 0;
  int            checks = 0;
  int unsigned   q_dest[$];
  flit_t         q_data[$];
  logic          exp_drop = 1'b0;

  always #5 clk = ~clk;

  input_unit #(
    .M      (M),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .DEST_W (DEST_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ce           (ce),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_en         (o_en),
    .o_output_req (o_output_req),
    .o_data       (o_data),
    .i_grant      (i_grant),
    .o_drop       (o_drop),
    .o_count      (o_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [0:M-1] model_req();
    logic [0:M-1] r = '0;
    if (q_dest.size() != 0) r[q_dest[0]] = 1'b1;
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 64'(o_count), 64'(q_dest.size()));
    chk({tag, ".req"},   64'(o_output_req), 64'(model_req()));
    chk({tag, ".en"},    64'(o_en), 64'(q_dest.size() != DEPTH));
    chk({tag, ".drop"},  64'(o_drop), 64'(exp_drop));
    if (q_data.size() != 0) chk({tag, ".data"}, 64'(o_data), 64'(q_data[0]));
  endtask

  // Drive one cycle of inputs, advance the model by the same rules, then check after the edge.
  task automatic cycle(input string tag, input bit c, input bit v, input int unsigned d, input bit g);
    int unsigned sz;
    flit_t       word;
    sz   = q_dest.size();
    word = flit_t'(($urandom() << DEST_W) | d);
    ce = c; i_valid = v; i_grant = g; i_data = word;
    exp_drop = c && v && (sz != DEPTH) && (d >= M);
    if (c && g && sz != 0) begin
      void'(q_dest.pop_front());
      void'(q_data.pop_front());
    end
    if (c && v && sz != DEPTH && d < M) begin
      q_dest.push_back(d);
      q_data.push_back(word);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; i_valid = 1'b0; i_grant = 1'b0; i_data = '0;
    #12;
    check_all("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    cycle("wr_dest2", 1, 1, 2, 0);
    cycle("idle", 1, 0, 0, 0);

    for (int i = 0; i < 3; i++) cycle("fill", 1, 1, $urandom_range(0, M-1), 0);
    cycle("wr_full", 1, 1, 1, 0);
    cycle("grant_full", 1, 1, 3, 1);
    cycle("drain", 1, 0, 0, 1);
    cycle("wr_and_grant", 1, 1, 4, 1);
    cycle("head_next", 1, 0, 0, 0);

    cycle("drop", 1, 1, 6, 0);
    cycle("drop_end", 1, 0, 0, 0);
    cycle("drop7", 1, 1, 7, 1);

    for (int i = 0; i < 3; i++) cycle("ce_low", 0, 1, 1, 1);
    cycle("ce_resume", 1, 1, 0, 1);
    cycle("ce_resume2", 1, 1, 3, 0);

    for (int i = 0; i < 400; i++) begin
      cycle("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 2) != 0);
    end

    for (int i = 0; i < DEPTH; i++) cycle("empty_out", 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle("to3", 1, 1, $urandom_range(0, M-1), 0);
    #3 reset_n = 1'b0;
    q_dest.delete();
    q_data.delete();
    exp_drop = 1'b0;
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle("post_rst", 1, 1, 0, 0);
    cycle("post_rst2", 1, 0, 0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/input_unit.md
# input_unit

Per-input-port buffer and request generator of the router, on the requesting side of the switch allocator. It accepts flits from the upstream link and stores them in a DEPTH-entry FIFO. It decodes each flit's destination into a one-hot output-port request, presents the head-of-line request to `switch_control`, and pops the head when granted. N instances feed the allocator's `i_output_req[n]` and consume `o_input_grant[n]`.

## Interface
- `M`, default 5: number of router output ports; request vector width.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `DATA_W`, default 32: flit width.
- `DEST_W`, default 3: destination field width, taken from `i_data[DEST_W-1:0]`.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce` in 1: clock enable; all state holds when low.
- `i_valid` in 1: upstream flit present.
- `i_data` in DATA_W: upstream flit.
- `o_en` out 1: space available; upstream may write.
- `o_output_req` out [0:M-1]: one-hot request for the head flit; all-zero when empty.
- `o_data` out DATA_W: head flit, valid whenever `o_output_req` is non-zero.
- `i_grant` in 1: input grant from the allocator; pops the head.
- `o_drop` out 1: one-cycle pulse when an incoming flit is discarded.
- `o_count` out clog2(DEPTH+1): current occupancy.

## Operation
- Write: a write is accepted on a rising `clk` with `ce && i_valid && o_en`.
  - If dest < M, store {one-hot(dest), `i_data`} at `wr_ptr`, advance `wr_ptr`, and increment count.
  - If dest ≥ M, do not store the flit. Pulse `o_drop` for one cycle and leave pointers and count unchanged.
- Read: a read happens on a rising `clk` with `ce && i_grant && count != 0`. Advance `rd_ptr` and decrement count. `i_grant` while empty is ignored.
- Simultaneous read and write in one cycle: both pointers advance and count is unchanged.
- `o_en` = (count != DEPTH). It is combinational from registered count, so it never depends on `i_grant` in the same cycle.
  - At full, a write is refused even if a pop occurs in that cycle.
- `o_output_req` = stored one-hot at `rd_ptr` when count != 0, else '0. It is never asserted on more than one bit.
- Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count saturates logically at DEPTH via `o_en`.
- `ce` low: no write, no read, and no `o_drop` pulse. Outputs continue to reflect the held state.
- Reset: asynchronous assertion clears pointers, count, and `o_drop` immediately. In-flight contents are lost; storage array contents need not be reset.

## Timing
- Reset values: `o_count` = 0, `o_output_req` = '0, `o_drop` = 0, `o_en` = 1. `o_data` is don't-care while `o_output_req` is zero.
- Write-to-request latency: 1 cycle. A flit written at edge k appears on `o_output_req`/`o_data` after edge k; no bypass.
- Grant-to-next-head: 1 cycle. After a popping edge, the next flit's request is visible, or '0 if none remain.
- `o_drop` is registered and high for exactly the cycle after the discarding edge.
- Back-to-back grants drain one flit per cycle.

## Structure
- `DEST_W`, the default M, and the flit typedef (`flit_t`, DATA_W bits) go in the shared `config.sv` package alongside existing router constants.
- Sub-module `fifo_sync`, parameterised by DEPTH and width:
  - Handles storage, pointers, and count.
  - Its width is M + DATA_W.
  - Stores the decoded request with the data so decode is off the allocator path.
- `input_unit` holds the destination decode, drop logic, and `o_output_req` gating.

## Test plan
- Reset, then write dest=2 (M=5) flit 0xA5 → next cycle `o_output_req`=00100, `o_data`=0xA5, `o_count`=1.
- Fill 4 flits with no grant → `o_en`=0 at count 4; a fifth `i_valid` is not stored. Grant at full → count 3 and `o_en`=1 the next cycle.
- Simultaneous write and grant at count 2 → count stays 2; head advances to the second flit in order.
- Write dest=6 (≥ M) → `o_drop` pulses for 1 cycle; count unchanged; `o_output_req` unchanged.
- `ce`=0 with `i_valid` and `i_grant` high for 3 cycles → count, head, and `o_drop` unchanged; resume with `ce`=1 → normal behaviour.
- Assert `reset_n` low mid-stream at count 3 → immediately `o_count`=0, `o_output_req`='0, `o_en`=1.
